time_display: RTL and testbench
===============================

# time_display

Display stage directly downstream of the seconds timer. It takes the timer's 7-bit elapsed-seconds count (0–127) and converts it to three BCD digits with a sequential shift-add-3 converter. It then drives a time-multiplexed, three-digit common-cathode 7-segment display. It also exposes the BCD value and a one-cycle update strobe for other consumers, such as a score or record comparator.

## Interface
- `CLK_HZ`, default 1_000_000, system clock frequency in Hz.
- `SCAN_HZ`, default 1000, digit-advance rate in Hz. `DIV = CLK_HZ/SCAN_HZ` must be an integer ≥ 2.
- `BLANK_LZ`, default 1, enables leading-zero blanking when set to 1.
- `clk`, input, 1 bit: system clock; all logic is on the rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `time_count`, input, 7 bits: elapsed seconds from the timer, unsigned.
- `blank`, input, 1 bit: forces all segments off while scanning continues.
- `bcd`, output, 12 bits: `{hundreds, tens, ones}` of the last converted value.
- `bcd_valid`, output, 1 bit: one-cycle pulse when `bcd` updates.
- `seg`, output, 7 bits: segments, active-high. `seg[0]`=a … `seg[6]`=g.
- `dig_sel`, output, 3 bits: one-hot, active-high digit enable. Bit 0 is ones, bit 2 is hundreds.

## Operation
- Converter FSM has three states: `IDLE`, `CONV`, `LOAD`.
  - `IDLE`: if `time_count` differs from `cache`, latch `time_count` into the low 7 bits of a 19-bit shift register (upper 12 bits zero) and go to `CONV` with `step`=0.
  - `CONV`: each cycle, add 3 to every BCD nibble ≥5, then shift left by 1. After 7 steps, go to `LOAD`.
  - `LOAD`: set `bcd` to the upper 12 bits of the shift register, set `cache` to the latched value, pulse `bcd_valid`, and return to `IDLE`.
- `time_count` changes during `CONV` or `LOAD` are ignored. On return to `IDLE`, the comparison against `cache` picks up the newest value.
- Scan logic:
  - A prescaler counts 0..`DIV`-1. When it wraps, the digit index advances 0→1→2→0.
  - `dig_sel` and `seg` are registered. Both are computed from the next index, so they change on the same edge.
- Segment decode (gfedcba, hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Blanking:
  - With `BLANK_LZ`=1, the hundreds digit outputs 00 when hundreds=0.
  - With `BLANK_LZ`=1, the tens digit outputs 00 when hundreds=0 and tens=0.
  - The ones digit is never blanked.
  - `blank`=1 forces `seg`=00 on the next edge.
- Reset values:
  - FSM=`IDLE`, `cache`=0, `bcd`=000, `bcd_valid`=0.
  - Prescaler=0, index=0, `dig_sel`=001, `seg`=3F.
  - `rst` during `CONV` aborts the conversion: `bcd` is left unchanged from its reset value and no strobe is issued.

## Timing
- Let E0 be the `IDLE` edge that samples a new value.
  - Shift steps occur on E1..E7.
  - `bcd` and `bcd_valid` are updated at E8, so latency is 8 cycles.
  - The earliest next sample is at E9.
- A `bcd` change appears on `seg` one cycle later, and only when its digit is the one selected.
- Each digit is held for exactly `DIV` cycles. A full refresh takes 3·`DIV` cycles.
- `bcd_valid` is high for exactly one cycle per conversion and never during reset.
- Value arithmetic: the hundreds nibble never exceeds 1. Nibble additions are 4-bit and cannot overflow, because the adjust is only applied to nibbles ≤9.

## Structure
- Shared package `display_pkg` holds:
  - `SEG_0`..`SEG_9` and `SEG_BLANK`, as 7-bit constants.
  - The enum `conv_state_t` with values `{IDLE, CONV, LOAD}`.
- Sub-module `bin2bcd_seq` contains the FSM, shift register, `cache`, `bcd` and `bcd_valid`.
- The parent `time_display` contains the prescaler, digit index, blanking and segment decode.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles → `bcd`=000, `bcd_valid`=0, `dig_sel`=001, `seg`=3F.
- **Full-scale conversion:** `time_count` steps 0→127 at E0 → single `bcd_valid` pulse at E8 with `bcd`=127. Scan then shows ones=07, tens=5B, hundreds=06.
- **Leading-zero blanking:** `time_count`=5 with `BLANK_LZ`=1 → hundreds `seg`=00, tens `seg`=00, ones `seg`=6D. Then assert `blank`=1 → all digits show 00 while `dig_sel` keeps rotating.
- **Change during conversion:** `time_count`=100 at E0, then 101 at E3 → `bcd`=100 at E8, `bcd`=101 at E17, two `bcd_valid` pulses.
- **Scan rate:** `CLK_HZ`=1000, `SCAN_HZ`=100 → `dig_sel` sequence 001→010→100→001, each held exactly 10 cycles.
- **Reset mid-conversion:** `time_count`=42 with `rst` pulsed at E4 → no strobe, `bcd`=000. After release, `bcd`=042 eight cycles after the first `IDLE` sample.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, converter state type and helpers for the
// seconds display stage.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } conv_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One double-dabble step: bias BCD nibbles >= 5, then shift.
   function automatic logic [18:0] add3_shift(input logic [18:0] v);
      logic [18:0] a;
      a = v;
      for (int i = 0; i < 3; i++) begin
         if (a[7+4*i +: 4] >= 4'd5)
            a[7+4*i +: 4] = a[7+4*i +: 4] + 4'd3;
      end
      return {a[17:0], 1'b0};
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 3-digit BCD converter; reconverts
// whenever the input differs from the last converted value.
module bin2bcd_seq
   import display_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  bin,
   output logic [11:0] bcd,
   output logic        bcd_valid
);

   conv_state_t state, state_d;
   logic [18:0] sr, sr_d;
   logic [2:0]  step, step_d;
   logic [6:0]  lat, lat_d;
   logic [6:0]  cache, cache_d;
   logic [11:0] bcd_d;
   logic        valid_d;

   always_comb begin
      state_d = state;
      sr_d    = sr;
      step_d  = step;
      lat_d   = lat;
      cache_d = cache;
      bcd_d   = bcd;
      valid_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (bin != cache) begin
               sr_d    = {12'd0, bin};
               lat_d   = bin;
               step_d  = 3'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            sr_d   = add3_shift(sr);
            step_d = step + 3'd1;
            if (step == 3'd6)
               state_d = LOAD;
         end
         LOAD: begin
            bcd_d   = sr[18:7];
            cache_d = lat;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sr        <= '0;
         step      <= '0;
         lat       <= '0;
         cache     <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         state     <= state_d;
         sr        <= sr_d;
         step      <= step_d;
         lat       <= lat_d;
         cache     <= cache_d;
         bcd       <= bcd_d;
         bcd_valid <= valid_d;
      end
   end

endmodule

// File: rtl/time_display.sv
// Seconds display: BCD conversion plus a three-digit multiplexed
// common-cathode 7-segment scanner with leading-zero blanking.
module time_display
   import display_pkg::*;
#(
   parameter int CLK_HZ   = 1_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  time_count,
   input  logic        blank,
   output logic [11:0] bcd,
   output logic        bcd_valid,
   output logic [6:0]  seg,
   output logic [2:0]  dig_sel
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] pre;
   logic [1:0]    idx, idx_d;
   logic          wrap;
   logic [3:0]    nib;
   logic          lz;
   logic [6:0]    seg_d;
   logic [2:0]    sel_d;

   bin2bcd_seq u_conv (
      .clk       (clk),
      .rst       (rst),
      .bin       (time_count),
      .bcd       (bcd),
      .bcd_valid (bcd_valid)
   );

   assign wrap = (pre == CW'(DIV - 1));

   always_comb begin
      idx_d = idx;
      if (wrap)
         idx_d = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   end

   // Outputs follow the next index so dig_sel and seg move together.
   always_comb begin
      nib = bcd[3:0];
      lz  = 1'b0;
      unique case (idx_d)
         2'd1: begin
            nib = bcd[7:4];
            lz  = BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0;
         end
         2'd2: begin
            nib = bcd[11:8];
            lz  = BLANK_LZ && bcd[11:8] == 4'd0;
         end
         default: begin
            nib = bcd[3:0];
            lz  = 1'b0;
         end
      endcase
      seg_d = (blank || lz) ? SEG_BLANK : seg_decode(nib);
      sel_d = 3'b001 << idx_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre     <= '0;
         idx     <= 2'd0;
         dig_sel <= 3'b001;
         seg     <= SEG_0;
      end else begin
         pre     <= wrap ? '0 : pre + CW'(1);
         idx     <= idx_d;
         dig_sel <= sel_d;
         seg     <= seg_d;
      end
   end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversion latency, scan order
// and timing, blanking and reset behaviour.
module tb_time_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  time_count;
   logic        blank;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;

   int n_vec = 0;
   int n_bad = 0;

   time_display #(
      .CLK_HZ   (1000),
      .SCAN_HZ  (100),
      .BLANK_LZ (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .time_count (time_count),
      .blank      (blank),
      .bcd        (bcd),
      .bcd_valid  (bcd_valid),
      .seg        (seg),
      .dig_sel    (dig_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [2:0] t);
      int n;
      n = 0;
      while (dig_sel !== t && n < 100) begin
         tick();
         n++;
      end
      check("wait_sel", {29'd0, dig_sel}, {29'd0, t});
   endtask

   task automatic hold_len(input logic [2:0] cur, input logic [2:0] nxt);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (dig_sel === cur && n < 100);
      check("hold_len", n, 10);
      check("next_sel", {29'd0, dig_sel}, {29'd0, nxt});
   endtask

   initial begin
      int pulses;
      rst        = 1'b1;
      time_count = 7'd0;
      blank      = 1'b0;
      tick();
      tick();
      check("rst_bcd",   {20'd0, bcd},       32'h000);
      check("rst_valid", {31'd0, bcd_valid}, 32'd0);
      check("rst_sel",   {29'd0, dig_sel},   32'd1);
      check("rst_seg",   {25'd0, seg},       32'h3F);
      rst = 1'b0;

      // full scale 0 -> 127
      time_count = 7'd127;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bcd_valid) pulses++;
         if (i == 7) check("fs_pre_valid", {31'd0, bcd_valid}, 32'd0);
         if (i == 8) begin
            check("fs_valid", {31'd0, bcd_valid}, 32'd1);
            check("fs_bcd",   {20'd0, bcd},       32'h127);
         end
      end
      check("fs_pulses", pulses, 1);
      wait_sel(3'b001);
      check("fs_ones", {25'd0, seg}, 32'h07);
      wait_sel(3'b010);
      check("fs_tens", {25'd0, seg}, 32'h5B);
      wait_sel(3'b100);
      check("fs_hund", {25'd0, seg}, 32'h06);

      // leading-zero blanking with value 5
      time_count = 7'd5;
      for (int i = 0; i < 20; i++) tick();
      check("lz_bcd", {20'd0, bcd}, 32'h005);
      wait_sel(3'b100);
      check("lz_hund", {25'd0, seg}, 32'h00);
      wait_sel(3'b010);
      check("lz_tens", {25'd0, seg}, 32'h00);
      wait_sel(3'b001);
      check("lz_ones", {25'd0, seg}, 32'h6D);
      blank = 1'b1;
      tick();
      check("blank_now", {25'd0, seg}, 32'h00);
      wait_sel(3'b010);
      check("blank_tens", {25'd0, seg}, 32'h00);
      wait_sel(3'b100);
      check("blank_hund", {25'd0, seg}, 32'h00);
      wait_sel(3'b001);
      check("blank_ones", {25'd0, seg}, 32'h00);
      blank = 1'b0;
      tick();
      check("unblank_ones", {25'd0, seg}, 32'h6D);

      // change during conversion: 100 then 101 at E3
      time_count = 7'd100;
      pulses = 0;
      for (int i = 0; i < 26; i++) begin
         tick();
         if (i == 2) time_count = 7'd101;
         if (bcd_valid) pulses++;
         if (i == 8) begin
            check("chg_v1",   {31'd0, bcd_valid}, 32'd1);
            check("chg_bcd1", {20'd0, bcd},       32'h100);
         end
         if (i == 17) begin
            check("chg_v2",   {31'd0, bcd_valid}, 32'd1);
            check("chg_bcd2", {20'd0, bcd},       32'h101);
         end
      end
      check("chg_pulses", pulses, 2);

      // scan rate: DIV = 10
      wait_sel(3'b001);
      wait_sel(3'b010);
      hold_len(3'b010, 3'b100);
      hold_len(3'b100, 3'b001);
      hold_len(3'b001, 3'b010);

      // reset mid-conversion
      time_count = 7'd42;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bcd_valid) pulses++;
         if (i == 3) rst = 1'b1;
      end
      tick();
      check("mr_bcd",   {20'd0, bcd},       32'h000);
      check("mr_valid", {31'd0, bcd_valid}, 32'd0);
      check("mr_sel",   {29'd0, dig_sel},   32'd1);
      rst = 1'b0;
      for (int j = 0; j <= 8; j++) begin
         tick();
         if (bcd_valid) pulses++;
         if (j == 7) check("mr_pre_bcd", {20'd0, bcd}, 32'h000);
         if (j == 8) begin
            check("mr_bcd42", {20'd0, bcd},       32'h042);
            check("mr_v42",   {31'd0, bcd_valid}, 32'd1);
         end
      end
      check("mr_pulses", pulses, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
